// File: rtl/jellyvl_stream_pkg.sv
// Shared helpers for the jellyvl valid/ready stream blocks.
//   ptr_width(depth) : bits needed to index a depth-entry buffer
//   occ_width(depth) : bits needed to count 0..depth entries
package jellyvl_stream_pkg;

  // A single-entry buffer still needs a 1-bit pointer to keep vectors legal.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/jellyvl_ready_delay_fifo.sv
// DEPTH-entry first-word-fall-through circular buffer used by jellyvl_ready_delay.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   cke            : clock enable, 0 holds all state
//   push/push_data : write one entry (caller guarantees not full)
//   pop            : drop the head entry (caller guarantees not empty)
//   occ_next       : occupancy after this cycle's push/pop
//   head           : current head entry, INIT_DATA when empty
//   head_valid     : buffer holds at least one entry
module jellyvl_ready_delay_fifo
  import jellyvl_stream_pkg::*;
#(
  parameter type         t_data    = logic [8-1:0],
  parameter int unsigned DEPTH     = 4,
  parameter t_data       INIT_DATA = 'x
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cke,
  input  logic                          push,
  input  t_data                         push_data,
  input  logic                          pop,
  output logic [occ_width(DEPTH)-1:0]   occ_next,
  output t_data                         head,
  output logic                          head_valid
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned OW = occ_width(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [OW-1:0] occ_t;

  localparam ptr_t PTR_LAST = PW'(DEPTH - 1);

  t_data mem [DEPTH];
  ptr_t  wr_ptr;
  ptr_t  rd_ptr;
  occ_t  occ;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    occ_next = occ + occ_t'(push) - occ_t'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (cke) begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      occ <= occ_next;
    end
  end

  // Head is read from storage only, so a pushed beat appears one cycle later.
  assign head_valid = (occ != '0);
  assign head       = head_valid ? mem[rd_ptr] : INIT_DATA;

endmodule

// File: rtl/jellyvl_ready_delay.sv
// Valid/ready register slice that retimes the ready path by LATENCY cycles.
// s_ready is a flop output with no combinational path from m_ready; a small
// FWFT buffer absorbs the beats still in flight while the delayed ready
// catches up. LATENCY==0 is a plain wire-through.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   cke               : clock enable, 0 freezes all state
//   s_data/s_valid    : upstream payload and valid
//   s_ready           : upstream ready (registered when LATENCY>0)
//   m_data/m_valid    : downstream payload (buffer head) and valid
//   m_ready           : downstream ready
module jellyvl_ready_delay
  import jellyvl_stream_pkg::*;
#(
  parameter type         t_data    = logic [8-1:0],
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned DEPTH     = 4,
  parameter t_data       INIT_DATA = 'x
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  cke,
  input  t_data s_data,
  input  logic  s_valid,
  output logic  s_ready,
  output t_data m_data,
  output logic  m_valid,
  input  logic  m_ready
);

  if (LATENCY == 0) begin : g_bypass

    assign s_ready = m_ready;
    assign m_data  = s_data;
    assign m_valid = s_valid;

    logic unused_bypass;
    assign unused_bypass = ^{clk, rst, cke};

  end else begin : g_delay

    if (DEPTH < LATENCY + 1) begin : g_depth_check
      $error("jellyvl_ready_delay: DEPTH (%0d) must be >= LATENCY+1 (%0d)", DEPTH, LATENCY + 1);
    end

    localparam int unsigned OW = occ_width(DEPTH);

    // Ready is granted only while enough free entries remain to absorb every
    // beat that can still arrive during the LATENCY cycles the pipe lags.
    localparam logic [OW-1:0] RDY_LIMIT = OW'(DEPTH - LATENCY);

    logic                push;
    logic                pop;
    logic [OW-1:0]       occ_next;
    logic [LATENCY-1:0]  rdy;

    assign push = cke & s_valid & s_ready;
    assign pop  = cke & m_valid & m_ready;

    jellyvl_ready_delay_fifo #(
      .t_data    (t_data),
      .DEPTH     (DEPTH),
      .INIT_DATA (INIT_DATA)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .cke        (cke),
      .push       (push),
      .push_data  (s_data),
      .pop        (pop),
      .occ_next   (occ_next),
      .head       (m_data),
      .head_valid (m_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdy <= '0;
      end else if (cke) begin
        rdy[0] <= (occ_next <= RDY_LIMIT);
        for (int unsigned i = 1; i < LATENCY; i++) begin
          rdy[i] <= rdy[i-1];
        end
      end
    end

    assign s_ready = rdy[LATENCY-1];

  end

endmodule
